ahb_decoder_ctrl: RTL and testbench

//  AHB-Lite address decoder and data-phase controller, directly upstream of the read-data multiplexer.

---
 rtl/ahb_pkg.sv | 29 ++
 rtl/ahb_default_slave.sv | 45 ++++
 rtl/ahb_decoder_ctrl.sv | 80 ++++++++
 tb/tb_ahb_decoder_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared encodings for the AHB-Lite decoder: transfer types, data-phase select codes
// and default-slave states.
package ahb_pkg;

  localparam int REGION_W = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] SEL_S1   = 3'b000;
  localparam logic [2:0] SEL_S2   = 3'b001;
  localparam logic [2:0] SEL_S3   = 3'b010;
  localparam logic [2:0] SEL_NONE = 3'b011;

  localparam logic [1:0] DS_IDLE = 2'b00;
  localparam logic [1:0] DS_ERR1 = 2'b01;
  localparam logic [1:0] DS_ERR2 = 2'b10;

  // One-hot address-phase decode to data-phase select code; no match -> SEL_NONE.
  function automatic logic [2:0] encode_sel(input logic s1, input logic s2, input logic s3);
    if (s1)      return SEL_S1;
    else if (s2) return SEL_S2;
    else if (s3) return SEL_S3;
    else         return SEL_NONE;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: answers an accepted unmapped NONSEQ/SEQ with a two-cycle
// ERROR response (wait + error, then ready + error).
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic hclk,
  input  logic hresetn,
  input  logic hready,
  input  logic start_err,
  output logic ds_hready,
  output logic ds_hresp
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (hready && start_err) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: begin
        // A new unmapped transfer accepted here chains straight into another error.
        if (hready) state_d = start_err ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    ds_hready = 1'b1;
    ds_hresp  = 1'b0;
    case (state_q)
      DS_ERR1: begin ds_hready = 1'b0; ds_hresp = 1'b1; end
      DS_ERR2: begin ds_hready = 1'b1; ds_hresp = 1'b1; end
      default: begin ds_hready = 1'b1; ds_hresp = 1'b0; end
    endcase
  end

endmodule

// File: rtl/ahb_decoder_ctrl.sv
// AHB-Lite address decoder and data-phase controller: address decode, registered
// read-mux select, and merge of slave ready/response with the default slave.
module ahb_decoder_ctrl
  import ahb_pkg::*;
#(
  parameter logic [REGION_W-1:0] S1_REGION = 4'h0,
  parameter logic [REGION_W-1:0] S2_REGION = 4'h1,
  parameter logic [REGION_W-1:0] S3_REGION = 4'h2
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hreadyout1,
  input  logic        hresp1,
  input  logic        hreadyout2,
  input  logic        hresp2,
  input  logic        hreadyout3,
  input  logic        hresp3,
  output logic        hsel1,
  output logic        hsel2,
  output logic        hsel3,
  output logic [2:0]  sel,
  output logic        hready,
  output logic        hresp
);

  logic [REGION_W-1:0] region;
  logic                unmapped;
  logic                start_err;
  logic [2:0]          sel_q;
  logic [2:0]          sel_d;
  logic                ds_hready;
  logic                ds_hresp;
  logic                unused_ok;

  assign region   = haddr[31:32-REGION_W];
  assign hsel1    = (region == S1_REGION);
  assign hsel2    = (region == S2_REGION);
  assign hsel3    = (region == S3_REGION);
  assign unmapped = ~(hsel1 | hsel2 | hsel3);

  // Only NONSEQ/SEQ (htrans[1] set) to an unmapped region earns an ERROR.
  assign start_err = unmapped & htrans[1];
  assign unused_ok = ^{haddr[31-REGION_W:0], htrans[0]};

  always_comb begin
    sel_d = sel_q;
    if (hready) sel_d = encode_sel(hsel1, hsel2, hsel3);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) sel_q <= SEL_NONE;
    else          sel_q <= sel_d;
  end

  assign sel = sel_q;

  ahb_default_slave u_default_slave (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hready    (hready),
    .start_err (start_err),
    .ds_hready (ds_hready),
    .ds_hresp  (ds_hresp)
  );

  // Illegal 1xx codes fall through to the default slave, same as SEL_NONE.
  always_comb begin
    hready = ds_hready;
    hresp  = ds_hresp;
    case (sel_q)
      SEL_S1:  begin hready = hreadyout1; hresp = hresp1; end
      SEL_S2:  begin hready = hreadyout2; hresp = hresp2; end
      SEL_S3:  begin hready = hreadyout3; hresp = hresp3; end
      default: begin hready = ds_hready;  hresp = ds_hresp; end
    endcase
  end

endmodule

// File: tb/tb_ahb_decoder_ctrl.sv
// Self-checking bench for ahb_decoder_ctrl: transaction-level model checked every
// negedge, plus directed literal checks for the named scenarios.
module tb_ahb_decoder_ctrl;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hreadyout1, hreadyout2, hreadyout3;
  logic        hresp1, hresp2, hresp3;
  logic        hsel1, hsel2, hsel3;
  logic [2:0]  sel;
  logic        hready, hresp;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state: slave owning the data phase (0 = none) and error cycles still to give.
  int m_target = 0;
  int m_err    = 0;

  always #5 hclk = ~hclk;

  ahb_decoder_ctrl dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .haddr      (haddr),
    .htrans     (htrans),
    .hreadyout1 (hreadyout1),
    .hresp1     (hresp1),
    .hreadyout2 (hreadyout2),
    .hresp2     (hresp2),
    .hreadyout3 (hreadyout3),
    .hresp3     (hresp3),
    .hsel1      (hsel1),
    .hsel2      (hsel2),
    .hsel3      (hsel3),
    .sel        (sel),
    .hready     (hready),
    .hresp      (hresp)
  );

  function automatic int decode(input logic [31:0] a);
    case (a[31:28])
      4'h0:    return 1;
      4'h1:    return 2;
      4'h2:    return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] exp_hsel();
    int d;
    d = decode(haddr);
    return (d == 0) ? 3'b000 : 3'(1 << (d - 1));
  endfunction

  function automatic logic [2:0] exp_sel();
    return (m_target == 0) ? 3'b011 : 3'(m_target - 1);
  endfunction

  function automatic logic exp_hready();
    case (m_target)
      1:       return hreadyout1;
      2:       return hreadyout2;
      3:       return hreadyout3;
      default: return (m_err != 2);
    endcase
  endfunction

  function automatic logic exp_hresp();
    case (m_target)
      1:       return hresp1;
      2:       return hresp2;
      3:       return hresp3;
      default: return (m_err != 0);
    endcase
  endfunction

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      m_target <= 0;
      m_err    <= 0;
    end else if (m_target == 0 && m_err == 2) begin
      m_err <= 1;
    end else if (exp_hready()) begin
      m_target <= decode(haddr);
      m_err    <= (decode(haddr) == 0 && htrans[1]) ? 2 : 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge hclk) begin
    if (chk_en) begin
      chk("model_hsel",   {29'd0, hsel3, hsel2, hsel1}, {29'd0, exp_hsel()});
      chk("model_sel",    {29'd0, sel},                 {29'd0, exp_sel()});
      chk("model_hready", {31'd0, hready},              {31'd0, exp_hready()});
      chk("model_hresp",  {31'd0, hresp},               {31'd0, exp_hresp()});
    end
  end

  task automatic drive(input logic [31:0] a, input logic [1:0] t,
                       input logic [2:0] ro, input logic [2:0] rp);
    @(posedge hclk);
    #2;
    haddr  = a;
    htrans = t;
    {hreadyout3, hreadyout2, hreadyout1} = ro;
    {hresp3, hresp2, hresp1} = rp;
    $display("txn t=%0t haddr=%h htrans=%b ready=%b resp=%b", $time, a, t, ro, rp);
    #1;
  endtask

  task automatic lit(input string name, input logic [2:0] e_sel, input logic e_rdy, input logic e_rsp);
    chk({name, "_sel"},    {29'd0, sel},    {29'd0, e_sel});
    chk({name, "_hready"}, {31'd0, hready}, {31'd0, e_rdy});
    chk({name, "_hresp"},  {31'd0, hresp},  {31'd0, e_rsp});
  endtask

  typedef struct {
    logic [31:0] a;
    logic [1:0]  t;
    logic [2:0]  ro;
    logic [2:0]  rp;
  } vec_t;

  vec_t vecs[14] = '{
    '{32'h0000_0000, 2'b10, 3'b111, 3'b001},
    '{32'h1000_0000, 2'b11, 3'b101, 3'b000},
    '{32'h1000_0000, 2'b11, 3'b111, 3'b010},
    '{32'h2FFF_FFFC, 2'b10, 3'b011, 3'b000},
    '{32'h2000_0000, 2'b10, 3'b111, 3'b100},
    '{32'h3000_0000, 2'b10, 3'b111, 3'b000},
    '{32'h3000_0000, 2'b01, 3'b111, 3'b000},
    '{32'hF000_0000, 2'b11, 3'b111, 3'b000},
    '{32'h0FFF_FFFF, 2'b10, 3'b110, 3'b000},
    '{32'h0FFF_FFFF, 2'b10, 3'b111, 3'b001},
    '{32'h4000_0000, 2'b00, 3'b111, 3'b000},
    '{32'h4000_0000, 2'b10, 3'b111, 3'b000},
    '{32'h1000_0010, 2'b10, 3'b111, 3'b000},
    '{32'h0000_0000, 2'b00, 3'b111, 3'b000}
  };

  initial begin
    haddr  = 32'h8000_0000;
    htrans = 2'b00;
    {hreadyout3, hreadyout2, hreadyout1} = 3'b111;
    {hresp3, hresp2, hresp1} = 3'b000;

    // Reset state with an unmapped address on the bus
    repeat (2) @(posedge hclk);
    #3;
    lit("reset", 3'b011, 1'b1, 1'b0);
    chk("reset_hsel", {29'd0, hsel3, hsel2, hsel1}, 32'd0);
    hresetn = 1'b1;
    chk_en  = 1'b1;

    // NONSEQ to slave 2: same-cycle decode, one-cycle select latency
    drive(32'h1000_0004, 2'b10, 3'b111, 3'b000);
    chk("s2_hsel", {29'd0, hsel3, hsel2, hsel1}, 32'h2);
    drive(32'h0000_0010, 2'b10, 3'b111, 3'b000);
    lit("s2_data", 3'b001, 1'b1, 1'b0);

    // Slave 1 inserts two wait states while the next address moves to slave 3
    drive(32'h2000_0000, 2'b10, 3'b110, 3'b000);
    lit("s1_wait1", 3'b000, 1'b0, 1'b0);
    drive(32'h2000_0000, 2'b10, 3'b110, 3'b000);
    lit("s1_wait2", 3'b000, 1'b0, 1'b0);
    drive(32'h2000_0000, 2'b10, 3'b111, 3'b000);
    lit("s1_done", 3'b000, 1'b1, 1'b0);
    drive(32'h8000_0000, 2'b10, 3'b111, 3'b000);
    lit("s3_data", 3'b010, 1'b1, 1'b0);

    // Unmapped NONSEQ: two-cycle ERROR, then IDLE to unmapped stays OKAY
    drive(32'h8000_0000, 2'b00, 3'b111, 3'b000);
    lit("err1", 3'b011, 1'b0, 1'b1);
    drive(32'h8000_0000, 2'b00, 3'b111, 3'b000);
    lit("err2", 3'b011, 1'b1, 1'b1);
    drive(32'h8000_0000, 2'b10, 3'b111, 3'b000);
    lit("idle_unmapped", 3'b011, 1'b1, 1'b0);

    // Back-to-back unmapped transfers, then a mapped transfer taken from ERR2
    drive(32'h9000_0000, 2'b11, 3'b111, 3'b000);
    lit("b2b_err1a", 3'b011, 1'b0, 1'b1);
    drive(32'h9000_0000, 2'b11, 3'b111, 3'b000);
    lit("b2b_err2a", 3'b011, 1'b1, 1'b1);
    drive(32'h0000_0000, 2'b10, 3'b111, 3'b000);
    lit("b2b_err1b", 3'b011, 1'b0, 1'b1);
    drive(32'h0000_0000, 2'b10, 3'b111, 3'b000);
    lit("b2b_err2b", 3'b011, 1'b1, 1'b1);
    drive(32'h8000_0000, 2'b10, 3'b111, 3'b000);
    lit("after_err", 3'b000, 1'b1, 1'b0);

    // Asynchronous reset in the middle of ERR1
    drive(32'h8000_0000, 2'b00, 3'b111, 3'b000);
    lit("pre_rst_err1", 3'b011, 1'b0, 1'b1);
    hresetn = 1'b0;
    #1;
    lit("async_rst", 3'b011, 1'b1, 1'b0);
    @(posedge hclk);
    #2;
    hresetn = 1'b1;

    // Directed table, checked by the model every cycle
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].a, vecs[i].t, vecs[i].ro, vecs[i].rp);
    end
    repeat (3) drive(32'h0000_0000, 2'b00, 3'b111, 3'b000);

    @(posedge hclk);
    #2;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
